sipo_rx: RTL

- Serial-in/parallel-out receiver; the capture end of the team's parallel-load/serial-shift transmitter chain.
- Shifts in WIDTH bits, LSB first, each qualified by shift_en_i.
- Presents the assembled word in an output holding register with a valid/ready handshake.
- Flags words lost because the consumer has not taken the previous word.

---
 rtl/sipo_rx_if.sv | 28 ++
 rtl/sipo_rx.sv | 70 +++++++
 2 files changed

// File: rtl/sipo_rx_if.sv
// Bus between the serial receiver and its consumer: serial bit strobe and
// resync inputs, plus the parallel word with its valid/ready handshake and status.
interface sipo_rx_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             serial_i;
    logic             shift_en_i;
    logic             clear_i;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             busy_o;
    logic [CNT_W-1:0] bit_cnt_o;
    logic             overrun_o;

    // master drives the serial stream and consumes words; slave is the receiver
    modport master (
        output serial_i, shift_en_i, clear_i, ready_i,
        input  data_o, valid_o, busy_o, bit_cnt_o, overrun_o
    );

    modport slave (
        input  serial_i, shift_en_i, clear_i, ready_i,
        output data_o, valid_o, busy_o, bit_cnt_o, overrun_o
    );
endinterface

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: assembles WIDTH bits LSB first and hands each
// word to the consumer through a one-entry holding register with overrun flag.
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    sipo_rx_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    // Only the upper WIDTH-1 bits of the shift register ever reach a word,
    // so the bit that would fall off the bottom is never stored.
    logic [WIDTH-2:0] partial_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;
    logic             overrun_reg;

    logic [WIDTH-1:0] word;
    logic             sample;
    logic             complete;
    logic             load;
    logic             drop;

    assign sample   = bus.shift_en_i & ~bus.clear_i;
    assign complete = sample && (bit_cnt_reg == CNT_W'(WIDTH - 1));
    assign word     = {bus.serial_i, partial_reg};
    // A consumer taking the old word in the completing cycle frees the buffer
    // for the new one, so back-to-back words never bubble or overrun.
    assign load     = complete && (!valid_reg || bus.ready_i);
    assign drop     = complete && valid_reg && !bus.ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            partial_reg <= '0;
            bit_cnt_reg <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (bus.clear_i) begin
                partial_reg <= '0;
                bit_cnt_reg <= '0;
            end else if (bus.shift_en_i) begin
                partial_reg <= word[WIDTH-1:1];
                bit_cnt_reg <= complete ? '0 : bit_cnt_reg + CNT_W'(1);
            end

            if (load) begin
                data_reg  <= word;
                valid_reg <= 1'b1;
            end else if (valid_reg && bus.ready_i) begin
                valid_reg <= 1'b0;
            end

            if (bus.clear_i) begin
                overrun_reg <= 1'b0;
            end else if (drop) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign bus.data_o    = data_reg;
    assign bus.valid_o   = valid_reg;
    assign bus.busy_o    = (bit_cnt_reg != '0);
    assign bus.bit_cnt_o = bit_cnt_reg;
    assign bus.overrun_o = overrun_reg;
endmodule
